// File: rtl/layer1_act_stream.sv
// layer1_act_stream: captures the layer-1 accumulator bus after a run, activates it and streams it out.
// Ports: clk, reset (sync, active-low), start (run pulse), acc_bus (OUTPUT_NODES packed signed nodes),
//        out_data/out_index/out_last/out_valid with out_ready handshake, busy, done (one-cycle pulse).
// Build option: define LAYER1_ACT_RELU_EN to apply max(x,0) at capture; otherwise values pass unmodified.
module layer1_act_stream #(
  parameter int DATA_WIDTH   = 8,
  parameter int INPUT_NODES  = 24,
  parameter int OUTPUT_NODES = 128,
  parameter int PE_LATENCY   = 2,
  localparam int IW = OUTPUT_NODES > 1 ? $clog2(OUTPUT_NODES) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] acc_bus,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [IW-1:0]                      out_index,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done
);
  localparam int AC = INPUT_NODES + PE_LATENCY;
  localparam int CW = AC > 1 ? $clog2(AC) : 1;
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ACCUM   = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] STREAM  = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DATA_WIDTH-1:0] mem [OUTPUT_NODES];
  logic acc_end;
  function automatic logic [DATA_WIDTH-1:0] act(input logic [DATA_WIDTH-1:0] v);
`ifdef LAYER1_ACT_RELU_EN
    return v[DATA_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction
  assign acc_end   = cnt == CW'(AC - 1);
  assign out_valid = state == STREAM;
  assign out_index = idx;
  assign out_last  = out_valid && idx == IW'(OUTPUT_NODES - 1);
  // gated so the idle/reset value is 0 even though the buffer is never cleared
  assign out_data  = out_valid ? mem[idx] : '0;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= start ? ACCUM : IDLE;
          cnt   <= '0;
        end
        ACCUM: begin
          state <= acc_end ? CAPTURE : ACCUM;
          cnt   <= acc_end ? '0 : cnt + 1'b1;
        end
        CAPTURE: begin
          state <= STREAM;
          idx   <= '0;
        end
        STREAM: if (out_ready) begin
          state <= out_last ? DONE : STREAM;
          idx   <= out_last ? '0 : idx + 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (state == CAPTURE)
      for (int k = 0; k < OUTPUT_NODES; k++) mem[k] <= act(acc_bus[DATA_WIDTH*k +: DATA_WIDTH]);
  end
endmodule
